load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: formats a single aligned byte/half/word access onto a simple
// valid/ready bus and returns aligned, extended load data.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic [31:0] load_result,
   output logic        bus_valid,
   output logic [31:0] bus_address,
   output logic [3:0]  bus_wstrobe,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] IDLE     = 2'b00;
   localparam logic [1:0] ACCESS   = 2'b01;
   localparam logic [1:0] COMPLETE = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic        load_q, load_d;
   logic        misal_q, misal_d;
   logic [3:0]  wstrobe_q, wstrobe_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] result_q, result_d;
   logic [1:0]  req_size_s;
   logic        req_misal_s;

   function automatic logic misaligned_of(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: misaligned_of = 1'b0;
         SZ_HALF: misaligned_of = a[0];
         default: misaligned_of = (a != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] wstrobe_of(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: wstrobe_of = 4'b0001 << a;
         SZ_HALF: wstrobe_of = 4'b0011 << a;
         default: wstrobe_of = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         SZ_BYTE: wdata_of = {4{d[7:0]}};
         SZ_HALF: wdata_of = {2{d[15:0]}};
         default: wdata_of = d;
      endcase
   endfunction

   function automatic logic [31:0] extract_of(input logic [1:0] sz, input logic [1:0] a,
                                              input logic uns, input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> {a, 3'b000};
      case (sz)
         SZ_BYTE: extract_of = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: extract_of = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default: extract_of = rd;
      endcase
   endfunction

   // Reserved size 11 behaves exactly like a word access from capture onward.
   assign req_size_s  = (size == 2'b11) ? SZ_WORD : size;
   assign req_misal_s = (is_load | is_store) & misaligned_of(req_size_s, address[1:0]);

   // Next-state and capture logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      load_d     = load_q;
      misal_d    = misal_q;
      wstrobe_d  = wstrobe_q;
      wdata_d    = wdata_q;
      result_d   = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d     = address;
               size_d     = req_size_s;
               unsigned_d = load_unsigned;
               load_d     = is_load;
               misal_d    = req_misal_s;
               // A load wins when both request bits are set, so it never writes.
               wstrobe_d  = (is_store & ~is_load) ? wstrobe_of(req_size_s, address[1:0]) : 4'b0000;
               wdata_d    = wdata_of(req_size_s, store_data);
               if ((is_load | is_store) && !req_misal_s) begin
                  state_d = ACCESS;
               end else begin
                  state_d = COMPLETE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (bus_ready) begin
               state_d = COMPLETE;
               if (load_q) begin
                  result_d = extract_of(size_q, addr_q[1:0], unsigned_q, bus_rdata);
               end else begin
                  result_d = result_q;
               end
            end else begin
               state_d = ACCESS;
            end
         end
         COMPLETE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State and captured request registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= 32'h0000_0000;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         load_q     <= 1'b0;
         misal_q    <= 1'b0;
         wstrobe_q  <= 4'b0000;
         wdata_q    <= 32'h0000_0000;
         result_q   <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         load_q     <= load_d;
         misal_q    <= misal_d;
         wstrobe_q  <= wstrobe_d;
         wdata_q    <= wdata_d;
         result_q   <= result_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == COMPLETE);
   assign misaligned  = (state_q == COMPLETE) & misal_q;
   assign bus_valid   = (state_q == ACCESS);
   assign bus_address = {addr_q[31:2], 2'b00};
   assign bus_wstrobe = wstrobe_q;
   assign bus_wdata   = wdata_q;
   assign load_result = result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; all stimulus changes and
// output samples happen on the falling clock edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic [31:0] load_result;
   logic        bus_valid;
   logic [31:0] bus_address;
   logic [3:0]  bus_wstrobe;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit dut (
      .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
      .size(size), .load_unsigned(load_unsigned), .address(address), .store_data(store_data),
      .busy(busy), .done(done), .misaligned(misaligned), .load_result(load_result),
      .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrobe(bus_wstrobe),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd);
      start = 1'b1; is_load = ld; is_store = st; size = sz;
      load_unsigned = uns; address = a; store_data = sd;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; size = 2'b00;
      load_unsigned = 1'b0; address = 32'h0; store_data = 32'h0;
      bus_ready = 1'b0; bus_rdata = 32'h0;
      @(negedge clk); @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_misal", {31'b0, misaligned}, 32'd0);
      check("rst_valid", {31'b0, bus_valid}, 32'd0);
      check("rst_result", load_result, 32'h0);
      check("rst_addr", bus_address, 32'h0);
      check("rst_wstrb", {28'b0, bus_wstrobe}, 32'h0);
      check("rst_wdata", bus_wdata, 32'h0);
      reset = 1'b0;

      // Signed byte load, ready on first ACCESS cycle
      request(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
      bus_ready = 1'b1; bus_rdata = 32'h80FF_FFFF;
      @(negedge clk); start = 1'b0;
      check("bl_valid", {31'b0, bus_valid}, 32'd1);
      check("bl_busy", {31'b0, busy}, 32'd1);
      check("bl_addr", bus_address, 32'h0000_1000);
      check("bl_wstrb", {28'b0, bus_wstrobe}, 32'h0);
      check("bl_done_early", {31'b0, done}, 32'd0);
      @(negedge clk); bus_ready = 1'b0;
      check("bl_done", {31'b0, done}, 32'd1);
      check("bl_misal", {31'b0, misaligned}, 32'd0);
      check("bl_valid_off", {31'b0, bus_valid}, 32'd0);
      check("bl_result", load_result, 32'hFFFF_FF80);
      @(negedge clk);
      check("bl_idle_done", {31'b0, done}, 32'd0);
      check("bl_idle_busy", {31'b0, busy}, 32'd0);

      // Unsigned half load with ready delayed for 3 cycles
      request(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
      bus_rdata = 32'hBEEF_1234;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("hl_valid", {31'b0, bus_valid}, 32'd1);
         check("hl_addr", bus_address, 32'h0000_2000);
         check("hl_done_early", {31'b0, done}, 32'd0);
         if (i == 2) bus_ready = 1'b1;
         @(negedge clk);
      end
      bus_ready = 1'b0;
      check("hl_done", {31'b0, done}, 32'd1);
      check("hl_result", load_result, 32'h0000_BEEF);
      @(negedge clk);

      // Byte store; load_result must hold
      request(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56AB);
      @(negedge clk); start = 1'b0;
      check("bs_valid", {31'b0, bus_valid}, 32'd1);
      check("bs_wstrb", {28'b0, bus_wstrobe}, 32'h2);
      check("bs_wdata", bus_wdata, 32'hABAB_ABAB);
      check("bs_addr", bus_address, 32'h0);
      bus_ready = 1'b1;
      @(negedge clk); bus_ready = 1'b0;
      check("bs_done", {31'b0, done}, 32'd1);
      check("bs_result", load_result, 32'h0000_BEEF);
      @(negedge clk);

      // Half store at offset 2
      request(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h9999_CDEF);
      @(negedge clk); start = 1'b0;
      check("hs_wstrb", {28'b0, bus_wstrobe}, 32'hC);
      check("hs_wdata", bus_wdata, 32'hCDEF_CDEF);
      check("hs_addr", bus_address, 32'h0000_0040);
      bus_ready = 1'b1;
      @(negedge clk); bus_ready = 1'b0;
      check("hs_done", {31'b0, done}, 32'd1);
      @(negedge clk);

      // Misaligned word load: no bus cycle, done+misaligned 1 cycle later
      request(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
      bus_rdata = 32'h1111_1111;
      @(negedge clk); start = 1'b0;
      check("mw_done", {31'b0, done}, 32'd1);
      check("mw_misal", {31'b0, misaligned}, 32'd1);
      check("mw_valid", {31'b0, bus_valid}, 32'd0);
      check("mw_result", load_result, 32'h0000_BEEF);
      @(negedge clk);
      check("mw_done_off", {31'b0, done}, 32'd0);
      check("mw_misal_off", {31'b0, misaligned}, 32'd0);
      check("mw_busy_off", {31'b0, busy}, 32'd0);

      // No-op request completes in 1 cycle without a bus cycle
      request(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      @(negedge clk); start = 1'b0;
      check("nop_done", {31'b0, done}, 32'd1);
      check("nop_misal", {31'b0, misaligned}, 32'd0);
      check("nop_valid", {31'b0, bus_valid}, 32'd0);
      @(negedge clk);

      // Load+store together acts as a load (reserved size = word)
      request(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'h5555_5555);
      bus_rdata = 32'h8765_4321;
      @(negedge clk); start = 1'b0;
      check("ls_wstrb", {28'b0, bus_wstrobe}, 32'h0);
      check("ls_valid", {31'b0, bus_valid}, 32'd1);
      bus_ready = 1'b1;
      @(negedge clk); bus_ready = 1'b0;
      check("ls_result", load_result, 32'h8765_4321);
      @(negedge clk);

      // Reset during ACCESS drops bus_valid asynchronously
      request(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
      @(negedge clk); start = 1'b0;
      check("ra_valid", {31'b0, bus_valid}, 32'd1);
      #2 reset = 1'b1;
      #1 check("ra_valid_drop", {31'b0, bus_valid}, 32'd0);
      @(negedge clk);
      check("ra_no_done", {31'b0, done}, 32'd0);
      check("ra_busy", {31'b0, busy}, 32'd0);
      check("ra_result_clr", load_result, 32'h0);
      reset = 1'b0;
      request(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0);
      bus_rdata = 32'hCAFE_F00D; bus_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      check("ra2_valid", {31'b0, bus_valid}, 32'd1);
      check("ra2_addr", bus_address, 32'h0000_3004);
      @(negedge clk); bus_ready = 1'b0;
      check("ra2_done", {31'b0, done}, 32'd1);
      check("ra2_result", load_result, 32'hCAFE_F00D);
      @(negedge clk);

      // Back-to-back: start held high across two requests
      request(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hAAAA_0001);
      bus_ready = 1'b1;
      @(negedge clk);
      check("bb1_valid", {31'b0, bus_valid}, 32'd1);
      check("bb1_wdata", bus_wdata, 32'hAAAA_0001);
      @(negedge clk);
      check("bb1_done", {31'b0, done}, 32'd1);
      address = 32'h0000_0020; store_data = 32'hBBBB_0002;
      @(negedge clk);
      check("bb_gap_busy", {31'b0, busy}, 32'd0);
      check("bb_gap_valid", {31'b0, bus_valid}, 32'd0);
      @(negedge clk);
      check("bb2_valid", {31'b0, bus_valid}, 32'd1);
      check("bb2_addr", bus_address, 32'h0000_0020);
      check("bb2_wdata", bus_wdata, 32'hBBBB_0002);
      start = 1'b0;
      @(negedge clk);
      check("bb2_done", {31'b0, done}, 32'd1);
      bus_ready = 1'b0;
      @(negedge clk);
      check("bb_end_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("bb_no_third", {31'b0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
